// File: rtl/bin_to_bcd_display_pkg.sv
// Shared types and defaults for the binary-to-BCD display front end.
package bin_to_bcd_display_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int          DIGIT_W         = 4;
   localparam int          MAX_VAL_DFLT    = 9999;
   localparam logic [3:0]  ERR_DIGIT_DFLT  = 4'hE;

endpackage

// File: rtl/bin_to_bcd_display_if.sv
// Request/result bundle between a requester and the BCD converter.
interface bin_to_bcd_display_if
   import bin_to_bcd_display_pkg::*;
#(
   parameter int IN_W     = 16,
   parameter int N_DIGITS = 4
);
   logic                        start;
   logic [IN_W-1:0]             bin_in;
   logic                        busy;
   logic                        done;
   logic                        ovf;
   logic [DIGIT_W*N_DIGITS-1:0] bcd_out;

   modport master (output start, bin_in, input busy, done, ovf, bcd_out);
   modport slave  (input start, bin_in, output busy, done, ovf, bcd_out);
endinterface

// File: rtl/bin_to_bcd_display_bcd_digit_adj.sv
// One shift-and-add-3 correction cell: digits 5..9 get +3 before the next shift.
module bcd_digit_adj
   import bin_to_bcd_display_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] adjusted
);
   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin_to_bcd_display.sv
// Sequential binary-to-BCD converter, one bit per clock; valid result 17 edges after start, overflow 1.
// start is ignored while busy; bcd_out holds the last result so the display stays stable.
module bin_to_bcd_display
   import bin_to_bcd_display_pkg::*;
#(
   parameter int         IN_W      = 16,
   parameter int         N_DIGITS  = 4,
   parameter int         MAX_VAL   = MAX_VAL_DFLT,
   parameter logic [3:0] ERR_DIGIT = ERR_DIGIT_DFLT
)(
   input  logic                   clk,
   input  logic                   reset,
   bin_to_bcd_display_if.slave    bus
);
   localparam int SCR_W = DIGIT_W * N_DIGITS;
   localparam int CNT_W = $clog2(IN_W);

   state_t              state, next_state;
   logic [IN_W-1:0]     shreg;
   logic [SCR_W-1:0]    scratch;
   logic [SCR_W-1:0]    adj;
   logic [CNT_W-1:0]    cnt;
   logic                ovf_int;
   logic [SCR_W-1:0]    bcd_q;
   logic                done_q;
   logic                ovf_q;
   logic                load, err_load, shift_en, fin;
   logic [SCR_W+IN_W-1:0] shifted;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (scratch[g*DIGIT_W +: DIGIT_W]),
         .adjusted (adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign shifted = {adj, shreg} << 1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      load       = 1'b0;
      err_load   = 1'b0;
      shift_en   = 1'b0;
      fin        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               // Out-of-range values skip the shift loop entirely.
               if (int'(bus.bin_in) > MAX_VAL) begin
                  err_load   = 1'b1;
                  next_state = FINISH;
               end else begin
                  load       = 1'b1;
                  next_state = SHIFT;
               end
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (cnt == CNT_W'(IN_W-1)) next_state = FINISH;
         end
         FINISH: begin
            fin        = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg   <= '0;
         scratch <= '0;
         cnt     <= '0;
         ovf_int <= 1'b0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= fin;
         if (load) begin
            shreg   <= bus.bin_in;
            scratch <= '0;
            cnt     <= '0;
            ovf_int <= 1'b0;
         end
         if (err_load) begin
            shreg   <= '0;
            scratch <= {N_DIGITS{ERR_DIGIT}};
            cnt     <= '0;
            ovf_int <= 1'b1;
         end
         if (shift_en) begin
            scratch <= shifted[SCR_W+IN_W-1:IN_W];
            shreg   <= shifted[IN_W-1:0];
            cnt     <= cnt + CNT_W'(1);
         end
         if (fin) begin
            bcd_q <= scratch;
            ovf_q <= ovf_int;
         end
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;
   assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Scoreboarded bench: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_bin_to_bcd_display;
   logic clk;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   busy_until = 0;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] last_bcd = '0;

   bin_to_bcd_display_if ifc ();

   bin_to_bcd_display dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] model_bcd(input int v);
      if (v > 9999) return 16'hEEEE;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Call between a negedge and the following posedge; that posedge samples start.
   task automatic issue(input int v);
      bit idle;
      exp_t e;
      idle = (cyc >= busy_until);
      ifc.start  = 1'b1;
      ifc.bin_in = 16'(v);
      @(posedge clk);
      #1;
      ifc.start  = 1'b0;
      ifc.bin_in = 16'($urandom);
      if (idle) begin
         e.bcd = model_bcd(v);
         e.ovf = (v > 9999);
         e.cyc = cyc + ((v > 9999) ? 1 : 17);
         busy_until = e.cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((cyc < busy_until || exp_q.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 32'(n), 32'(0));
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         last_bcd = '0;
      end else begin
         if (ifc.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(ifc.bcd_out), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("bcd_out", 32'(ifc.bcd_out), 32'(e.bcd));
               chk("ovf", 32'(ifc.ovf), 32'(e.ovf));
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else begin
            chk("bcd_hold", 32'(ifc.bcd_out), 32'(last_bcd));
         end
         last_bcd = ifc.bcd_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int e0, n, v;
      reset      = 1'b1;
      ifc.start  = 1'b0;
      ifc.bin_in = '0;
      #3;
      chk("rst_busy", 32'(ifc.busy), 32'(0));
      chk("rst_done", 32'(ifc.done), 32'(0));
      chk("rst_ovf",  32'(ifc.ovf),  32'(0));
      chk("rst_bcd",  32'(ifc.bcd_out), 32'(0));
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Zero input: busy spans the 16 shifts plus the finish state.
      @(negedge clk);
      issue(0);
      n = 0;
      @(negedge clk);
      while (ifc.busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("busy_len", 32'(n), 32'(17));
      wait_idle();

      issue(1234);
      wait_idle();
      issue(9999);
      wait_idle();
      issue(10000);
      wait_idle();
      issue(7);
      wait_idle();

      // Second start during a conversion must be dropped.
      issue(42);
      e0 = cyc;
      while (cyc < e0 + 4) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      issue(555);
      wait_idle();

      // Start raised in the done cycle is accepted immediately.
      issue(42);
      while (cyc < busy_until) @(negedge clk);
      issue(305);
      wait_idle();

      // Asynchronous reset in the middle of a conversion.
      issue(8191);
      e0 = cyc;
      while (cyc < e0 + 9) begin
         @(posedge clk);
         #1;
      end
      #1;
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(ifc.busy), 32'(0));
      chk("abort_done", 32'(ifc.done), 32'(0));
      chk("abort_ovf",  32'(ifc.ovf),  32'(0));
      chk("abort_bcd",  32'(ifc.bcd_out), 32'(0));
      exp_q.delete();
      busy_until = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(8191);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535))
                                         : int'($urandom_range(0, 9999));
         @(negedge clk);
         issue(v);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            @(negedge clk);
            issue(int'($urandom_range(0, 65535)));
         end
         if ($urandom_range(0, 1) == 0) wait_idle();
      end
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
